// File: rtl/fifo_pkg.sv
// Definitions shared by linear_fifo and its consumers: default entry width,
// the packer FSM state type and an elaboration-time ceil(log2) helper.
package fifo_pkg;

    localparam int DATA_W_DEF = 4;

    typedef enum logic {
        FILL = 1'b0,
        OUT  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_nibble_packer.sv
// Drains linear_fifo entries and packs NIBBLES of them into one word on a
// valid/ready interface; a flush emits a zero-padded partial word.
module fifo_nibble_packer
    import fifo_pkg::*;
#(
    parameter int  DATA_W    = DATA_W_DEF,
    parameter int  NIBBLES   = 4,
    parameter bit  FIRST_MSB = 1'b0,
    localparam int WORD_W    = DATA_W * NIBBLES,
    localparam int CNT_W     = clog2(NIBBLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dataout,
    output logic              fifo_read_enb,
    input  logic              flush,
    output logic [WORD_W-1:0] word_out,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              word_valid,
    input  logic              word_ready
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rd_pending_q, rd_pending_d;
    logic                flush_pend_q, flush_pend_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [WORD_W-1:0]   word_out_q, word_out_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic                word_valid_q, word_valid_d;

    logic [CNT_W:0]      fill_level;
    logic [CNT_W-1:0]    cnt_cap;
    logic [WORD_W-1:0]   shreg_cap;
    logic                word_full;
    logic                flush_act;
    logic                handshake;

    function automatic int slot_lsb(input int k);
        return FIRST_MSB ? (NIBBLES - 1 - k) * DATA_W : k * DATA_W;
    endfunction

    function automatic logic [WORD_W-1:0] place(input logic [WORD_W-1:0] w,
                                                input logic [CNT_W-1:0]  slot,
                                                input logic [DATA_W-1:0] d);
        logic [WORD_W-1:0] r;
        r = w;
        for (int k = 0; k < NIBBLES; k++) begin
            if (slot == CNT_W'(k)) begin
                r[slot_lsb(k) +: DATA_W] = d;
            end
        end
        return r;
    endfunction

    // Entries already held plus the one in flight must leave room for another.
    assign fill_level    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, rd_pending_q};
    assign fifo_read_enb = !rst && (state_q == FILL) && !fifo_empty && !flush_pend_q
                           && (fill_level < (CNT_W + 1)'(NIBBLES));
    assign rd_pending_d  = fifo_read_enb;

    always_comb begin
        cnt_cap   = cnt_q;
        shreg_cap = shreg_q;
        if (rd_pending_q) begin
            shreg_cap = place(shreg_q, cnt_q, fifo_dataout);
            cnt_cap   = cnt_q + CNT_W'(1);
        end
    end

    // A flush waits for any in-flight read so that entry lands in the word.
    assign word_full = (state_q == FILL) && rd_pending_q && (cnt_cap == CNT_W'(NIBBLES));
    assign flush_act = (state_q == FILL) && flush_pend_q && !rd_pending_q;
    assign handshake = word_valid_q && word_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (word_full || (flush_act && (cnt_q != '0))) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (handshake) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        word_out_d   = word_out_q;
        word_cnt_d   = word_cnt_q;
        word_valid_d = word_valid_q;
        flush_pend_d = flush_pend_q | flush;
        case (state_q)
            FILL: begin
                cnt_d   = cnt_cap;
                shreg_d = shreg_cap;
                if (word_full) begin
                    word_out_d   = shreg_cap;
                    word_cnt_d   = CNT_W'(NIBBLES);
                    word_valid_d = 1'b1;
                end else if (flush_act) begin
                    flush_pend_d = flush;
                    if (cnt_q != '0) begin
                        word_out_d   = shreg_q;
                        word_cnt_d   = cnt_q;
                        word_valid_d = 1'b1;
                    end
                end
            end
            OUT: begin
                if (handshake) begin
                    word_valid_d = 1'b0;
                    cnt_d        = '0;
                    shreg_d      = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            rd_pending_q <= 1'b0;
            flush_pend_q <= 1'b0;
            shreg_q      <= '0;
            word_out_q   <= '0;
            word_cnt_q   <= '0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            rd_pending_q <= rd_pending_d;
            flush_pend_q <= flush_pend_d;
            shreg_q      <= shreg_d;
            word_out_q   <= word_out_d;
            word_cnt_q   <= word_cnt_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_out   = word_out_q;
    assign word_cnt   = word_cnt_q;
    assign word_valid = word_valid_q;

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Scoreboard bench: a queue-based FIFO model feeds two packers (LSB-first and
// MSB-first); expected words come from grouping the consumed entry stream.
module tb_fifo_nibble_packer;

    localparam int DW = 4;
    localparam int NB = 4;
    localparam int WW = DW * NB;
    localparam int CW = 3;

    typedef struct {
        logic [WW-1:0] w_lsb;
        logic [WW-1:0] w_msb;
        int            cnt;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dataout;
    logic          fifo_read_enb;
    logic          flush;
    logic [WW-1:0] word_out;
    logic [CW-1:0] word_cnt;
    logic          word_valid;
    logic          word_ready;

    logic          fifo_read_enb_m;
    logic [WW-1:0] word_out_m;
    logic [CW-1:0] word_cnt_m;
    logic          word_valid_m;

    exp_t          exp_q[$];
    logic [DW-1:0] fq[$];
    logic [DW-1:0] cur[$];
    logic [WW-1:0] log_q[$];
    logic [WW-1:0] log_m[$];
    int            log_c[$];

    int tests;
    int fails;
    int reads;
    bit pend_rd;
    bit pend_flush;

    fifo_nibble_packer #(.DATA_W(DW), .NIBBLES(NB), .FIRST_MSB(1'b0)) u_dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dataout(fifo_dataout),
        .fifo_read_enb(fifo_read_enb), .flush(flush), .word_out(word_out),
        .word_cnt(word_cnt), .word_valid(word_valid), .word_ready(word_ready)
    );

    fifo_nibble_packer #(.DATA_W(DW), .NIBBLES(NB), .FIRST_MSB(1'b1)) u_dut_msb (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dataout(fifo_dataout),
        .fifo_read_enb(fifo_read_enb_m), .flush(flush), .word_out(word_out_m),
        .word_cnt(word_cnt_m), .word_valid(word_valid_m), .word_ready(word_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic void emit();
        exp_t e;
        e.w_lsb = '0;
        e.w_msb = '0;
        for (int i = 0; i < cur.size(); i++) begin
            e.w_lsb[i*DW +: DW]        = cur[i];
            e.w_msb[(NB-1-i)*DW +: DW] = cur[i];
        end
        e.cnt = cur.size();
        exp_q.push_back(e);
        cur.delete();
    endfunction

    function automatic longint log_at(input int idx);
        if (idx < log_q.size()) return longint'(log_q[idx]);
        return 64'hFFFF_FFFF;
    endfunction

    function automatic longint logm_at(input int idx);
        if (idx < log_m.size()) return longint'(log_m[idx]);
        return 64'hFFFF_FFFF;
    endfunction

    function automatic longint logc_at(input int idx);
        if (idx < log_c.size()) return longint'(log_c[idx]);
        return 64'hFFFF_FFFF;
    endfunction

    // One clock of environment: deliver last read's data, apply inputs, note the strobe.
    task automatic step(input bit f, input bit r, input bit rs);
        @(negedge clk);
        if (pend_rd && fq.size() > 0) begin
            fifo_dataout = fq.pop_front();
            cur.push_back(fifo_dataout);
            if (cur.size() == NB) emit();
        end
        if (pend_flush && cur.size() > 0) emit();
        rst        = rs;
        flush      = f;
        word_ready = r;
        fifo_empty = (fq.size() == 0);
        #1;
        pend_rd    = fifo_read_enb;
        pend_flush = f && !rs;
        if (pend_rd) reads++;
        if (fifo_read_enb && fifo_empty) chk("rd_while_empty", 1, 0);
        if (rs) begin
            cur.delete();
            exp_q.delete();
            pend_flush = 1'b0;
        end
    endtask

    task automatic run_until_words(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            step(1'b0, 1'b1, 1'b0);
            k++;
        end
        step(1'b0, 1'b1, 1'b0);
        if (log_q.size() < n) chk(name, log_q.size(), n);
    endtask

    // Monitor: check every accepted word against the scoreboard and hold stability.
    initial begin : monitor
        logic          hold;
        logic [WW-1:0] held_w;
        logic [CW-1:0] held_c;
        exp_t          e;
        hold = 1'b0;
        held_w = '0;
        held_c = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && word_valid) begin
                chk("valid_msb", word_valid_m, 1);
                if (hold) begin
                    chk("hold_word", word_out, held_w);
                    chk("hold_cnt", word_cnt, held_c);
                end
                if (word_ready) begin
                    hold = 1'b0;
                    log_q.push_back(word_out);
                    log_m.push_back(word_out_m);
                    log_c.push_back(int'(word_cnt));
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", word_out, 64'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_word", word_out, e.w_lsb);
                        chk("sb_word_msb", word_out_m, e.w_msb);
                        chk("sb_cnt", word_cnt, e.cnt);
                        chk("sb_cnt_msb", word_cnt_m, e.cnt);
                    end
                end else begin
                    hold   = 1'b1;
                    held_w = word_out;
                    held_c = word_cnt;
                end
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int b;
        int r0;
        int k;
        rst = 1'b1; flush = 1'b0; word_ready = 1'b1; fifo_empty = 1'b1; fifo_dataout = '0;
        pend_rd = 1'b0; pend_flush = 1'b0; tests = 0; fails = 0; reads = 0;

        // Reset state
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("rst_rd_enb", fifo_read_enb, 0);
        step(1'b0, 1'b1, 1'b0);
        chk("rst_valid", word_valid, 0);
        chk("rst_word", word_out, 0);
        chk("rst_cnt", word_cnt, 0);

        // Full drain of 1..15,0
        b = log_q.size();
        r0 = reads;
        for (int i = 1; i <= 16; i++) fq.push_back(DW'(i % 16));
        run_until_words("t1_timeout", b + 4, 100);
        chk("t1_w0", log_at(b), 16'h4321);
        chk("t1_w1", log_at(b + 1), 16'h8765);
        chk("t1_w2", log_at(b + 2), 16'hCBA9);
        chk("t1_w3", log_at(b + 3), 16'h0FED);
        chk("t1_c0", logc_at(b), 4);
        chk("t1_msb_w0", logm_at(b), 16'h1234);
        chk("t1_reads", reads - r0, 16);
        chk("t1_fifo_empty", fq.size(), 0);

        // Backpressure
        b = log_q.size();
        for (int i = 1; i <= 16; i++) fq.push_back(DW'(i % 16));
        k = 0;
        while (!word_valid && k < 50) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end
        chk("bp_valid_seen", word_valid, 1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("bp_word", word_out, 16'h4321);
            chk("bp_valid", word_valid, 1);
            chk("bp_rd_enb", fifo_read_enb, 0);
        end
        chk("bp_fifo_level", fq.size(), 12);
        run_until_words("bp_timeout", b + 4, 100);
        chk("bp_w0", log_at(b), 16'h4321);
        chk("bp_w1", log_at(b + 1), 16'h8765);

        // Flush of a partial word
        b = log_q.size();
        fq.push_back(4'hA); fq.push_back(4'hB); fq.push_back(4'hC);
        repeat (8) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("fl_pre_valid", word_valid, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("fl_lat_valid", word_valid, 1);
        chk("fl_word", word_out, 16'h0CBA);
        chk("fl_cnt", word_cnt, 3);
        run_until_words("fl_timeout", b + 1, 20);
        chk("fl_log", log_at(b), 16'h0CBA);

        // Flush with nothing gathered is a no-op
        b = log_q.size();
        step(1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b0);
        chk("fl_empty_noword", log_q.size() - b, 0);

        // Flush racing the capture of the second entry
        b = log_q.size();
        r0 = reads;
        fq.push_back(4'h7); fq.push_back(4'h5);
        k = 0;
        while (reads - r0 < 2 && k < 20) begin
            step(1'b0, 1'b1, 1'b0);
            k++;
        end
        step(1'b1, 1'b1, 1'b0);
        run_until_words("race_timeout", b + 1, 20);
        chk("race_word", log_at(b), 16'h0057);
        chk("race_cnt", logc_at(b), 2);

        // Reset with two entries held and a read in flight
        r0 = reads;
        fq.push_back(4'h1); fq.push_back(4'h2); fq.push_back(4'h3);
        k = 0;
        while (reads - r0 < 3 && k < 20) begin
            step(1'b0, 1'b1, 1'b0);
            k++;
        end
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("mr_valid", word_valid, 0);
        chk("mr_word", word_out, 0);
        chk("mr_cnt", word_cnt, 0);
        b = log_q.size();
        fq.push_back(4'h6); fq.push_back(4'h7); fq.push_back(4'h8); fq.push_back(4'h9);
        run_until_words("mr_timeout", b + 1, 30);
        chk("mr_word_after", log_at(b), 16'h9876);
        chk("mr_msb_after", logm_at(b), 16'h6789);
        repeat (6) step(1'b0, 1'b1, 1'b0);
        chk("mr_single_word", log_q.size() - b, 1);

        // Randomized traffic, backpressure and flushes
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0 && fq.size() < 16) fq.push_back(DW'($urandom_range(0, 15)));
            step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, 1'b0);
        end
        repeat (60) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        k = 0;
        while ((exp_q.size() > 0 || fq.size() > 0) && k < 200) begin
            step(1'b0, 1'b1, 1'b0);
            k++;
        end
        repeat (4) step(1'b0, 1'b1, 1'b0);
        chk("drain_sb_empty", exp_q.size(), 0);
        chk("drain_partial", cur.size(), 0);
        chk("drain_fifo", fq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_nibble_packer.md
Name: fifo_nibble_packer

Overview:
- Downstream consumer of linear_fifo.
- Drains DATA_W-bit entries from the FIFO read port and packs NIBBLES consecutive entries into one WORD_W-bit word.
- Presents each word on a valid/ready output interface.
- A flush request emits a partially filled word, zero-padded, with its fill count.

Parameters:
- DATA_W, 4, width of one FIFO entry; matches linear_fifo datain/dataout.
- NIBBLES, 4, entries packed per output word; legal range 2..16.
- FIRST_MSB, 0: 0 puts the first entry in bits [DATA_W-1:0]; 1 puts it in the top DATA_W bits.
- Derived, not overridable:
  - WORD_W = DATA_W*NIBBLES.
  - CNT_W = clog2(NIBBLES+1).

Ports:
- clk  in  1  rising-edge clock, shared with linear_fifo.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dataout  in  DATA_W  FIFO read data, valid the cycle after an accepted read.
- fifo_read_enb  out  1  FIFO read strobe; drives linear_fifo read_enb.
- flush  in  1  single-cycle request to emit a partial word.
- word_out  out  WORD_W  packed word.
- word_cnt  out  CNT_W  number of valid entries in word_out (NIBBLES, or fewer after a flush).
- word_valid  out  1  word_out/word_cnt valid.
- word_ready  in  1  downstream accepts the word.

Behaviour:
- Reset: clk is the only clock. When rst=1 at a rising edge:
  - state, cnt, rd_pending, flush_pend, shift register, word_out and word_cnt are all cleared to 0.
  - word_valid=0 and fifo_read_enb=0.
  - This applies in any state. A read issued in the reset cycle has its returned data discarded.
- FIFO read contract: linear_fifo has registered read data. A read strobe while fifo_empty=0 yields data on fifo_dataout exactly one cycle later. A strobe while empty is never issued.
- States:
  - FILL: gather entries.
  - OUT: hold the word until accepted.
- fifo_read_enb is combinational. It is 1 only when all hold:
  - state=FILL
  - fifo_empty=0
  - flush_pend=0
  - cnt + rd_pending < NIBBLES
- Throughput: one read per cycle is sustained.
- rd_pending <= fifo_read_enb each cycle.
- Capture: when rd_pending=1, fifo_dataout is written into slot cnt and cnt increments.
  - Slot k occupies bits [k*DATA_W +: DATA_W] when FIRST_MSB=0.
  - Slot k occupies bits [(NIBBLES-1-k)*DATA_W +: DATA_W] when FIRST_MSB=1.
- Word completion: when the capture makes cnt reach NIBBLES, the next cycle has:
  - state=OUT, word_valid=1, word_cnt=NIBBLES.
  - Latency is 1 cycle from capture of the last entry to word_valid.
- OUT:
  - word_out and word_cnt are stable while word_valid=1 and word_ready=0.
  - A handshake (word_valid & word_ready at an edge) returns to FILL with cnt=0 and the shift register cleared.
  - No FIFO reads are issued in OUT.
- Flush:
  - flush=1 in FILL sets flush_pend, which blocks new reads.
  - Once rd_pending=0:
    - if cnt>0: emit the word with unfilled slots = 0 and word_cnt=cnt; go to OUT.
    - if cnt=0: clear flush_pend with no output.
  - flush in OUT is latched into flush_pend and acted on after return to FILL.
  - flush_pend clears on the emit, or on the cnt=0 no-op.
- Simultaneous capture and flush in the same cycle: the capture counts, and that entry is included in the flushed word.
- FIFO empty mid-word: the packer waits in FILL indefinitely with a partial cnt; there is no timeout.
- Outputs are registered except fifo_read_enb.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_W default
  - the clog2 function
  - a state enum {FILL, OUT}
- linear_fifo and this block both import fifo_pkg.
- No sub-module. A top wrapper fifo_pack_top instantiating linear_fifo + fifo_nibble_packer is natural for integration testing, but is not part of this block.

Test Plan:
- Defaults. Write 1,2,...,15,0 into linear_fifo (16 entries, full), word_ready=1.
  - Response: words 0x4321, 0x8765, 0xCBA9, 0x0FED, each with word_cnt=4.
  - fifo_read_enb high on 16 of the drain cycles; FIFO empty at the end.
- Backpressure. word_ready=0 for 10 cycles after the first word_valid.
  - Response: word_out stays 0x4321 and word_valid stays 1.
  - fifo_read_enb=0 throughout; FIFO holds the remaining 12 entries.
  - Release gives 0x8765 next.
- Flush partial. Write 0xA,0xB,0xC, wait until captured, pulse flush.
  - Response: word_out=0x0CBA, word_cnt=3, 1 cycle after the flush takes effect.
  - flush with cnt=0 produces no word_valid.
- Flush racing a read. Pulse flush in the cycle rd_pending=1 for the second entry (0x5 after 0x7).
  - Response: word_out=0x0057, word_cnt=2.
- FIRST_MSB=1. Write 1,2,3,4.
  - Response: word_out=0x1234.
- Reset mid-word. After 2 entries captured with a read in flight, hold rst=1 for 1 cycle.
  - Response: word_valid=0, cnt=0, and no stale entry is captured.
  - Next 4 FIFO entries 6,7,8,9 give 0x9876.
